goboard_writer: RTL and testbench
=================================

Name: goboard_writer

Overview:
- Write-side owner of the board pieces memory: takes move commands from the game logic and does read-modify-write on an internal 19-row shadow of the board.
- Drives the memory's sys-clock write port one row per write; the VGA pieces renderer reads the other port.
- Row encoding: bit 2x = black stone at column x, bit 2x+1 = white stone at column x.
- Also keeps per-colour stone counts and bulk-clears the board.

Parameters:
- SIZE, 19, board dimension (rows and columns); the memory row width is 2*SIZE = 38 bits.
- AW, 5, memory address width.

Ports:
- sys_clk_in  input  1  system clock; sole clock.
- rst_i  input  1  synchronous, active-high reset.
- cmd_valid_i  input  1  command offered.
- cmd_ready_o  output  1  block can accept a command.
- cmd_op_i  input  2  00 place black, 01 place white, 10 remove, 11 clear board.
- cmd_x_i  input  5  column, 0..SIZE-1.
- cmd_y_i  input  5  row, 0..SIZE-1.
- done_o  output  1  one-cycle pulse, command finished.
- status_o  output  2  valid with done_o: 00 ok, 01 occupied, 10 out of range, 11 empty (remove on empty point).
- addr_o  output  AW  memory write address.
- pieces_o  output  2*SIZE  memory write data.
- wEnable_o  output  1  memory write strobe.
- black_cnt_o  output  9  black stones on board, 0..361.
- white_cnt_o  output  9  white stones on board, 0..361.

Behaviour:
- Handshake: a command is accepted on a cycle where cmd_valid_i && cmd_ready_o. Command fields are captured on that cycle. Inputs are ignored when not accepted.
- FSM states and transitions:
  - CLEAR -> IDLE after row SIZE-1 is written.
  - IDLE -> WRITE on an accepted place or remove that is ok.
  - IDLE -> CLEAR on an accepted op 11.
  - IDLE stays IDLE on an accepted command that is rejected.
  - WRITE -> IDLE after one cycle.
- cmd_ready_o = 1 only in IDLE.
- Reset:
  - Shadow rows and both counts go to 0.
  - done_o, wEnable_o and status_o go to 0; addr_o and pieces_o go to 0.
  - FSM enters CLEAR with row counter 0, so memory matches the shadow after reset.
  - Reset asserted mid-CLEAR or mid-WRITE restarts CLEAR from row 0 on the next cycle.
- Command checks, done combinationally on the accept cycle T, in this priority:
  1. x >= SIZE or y >= SIZE -> status 10.
  2. Place on a point with either bit set -> status 01.
  3. Remove on a point with both bits clear -> status 11.
  4. Otherwise ok.
- Rejected command:
  - done_o = 1 and status_o set at T+1.
  - No memory write; shadow and counts unchanged.
- Ok place or remove:
  - At T+1 the shadow row y is updated: set bit 2x or 2x+1 for place; clear both bits for remove.
  - Also at T+1: wEnable_o = 1, addr_o = y, pieces_o = the updated row, done_o = 1, status 00.
  - Count changes are visible at T+1: place increments the stone's colour count; remove decrements the colour of the removed stone.
  - Latency from accept to write is 1 cycle. Back-to-back command throughput is one command per 2 cycles.
- CLEAR:
  - For r = 0..SIZE-1 on consecutive cycles: wEnable_o = 1, addr_o = r, pieces_o = 0, shadow row r cleared.
  - Counts go to 0 on the first CLEAR cycle.
  - done_o = 1 with status 00 on the cycle row SIZE-1 is written.
  - CLEAR entered from reset does not pulse done_o.
- wEnable_o is never high for addresses >= SIZE; rows SIZE..31 are never written.
- Output registers: all memory-port outputs are registered; addr_o and pieces_o hold their last value when wEnable_o = 0.
- Width rules: counts saturate neither way; they cannot exceed 361 and cannot go below 0 by construction.

Decomposition:
- Shared package goboard_pkg:
  - SIZE, AW, ROW_W = 2*SIZE.
  - Op codes OP_PLACE_B, OP_PLACE_W, OP_REMOVE, OP_CLEAR.
  - Status codes ST_OK, ST_OCCUPIED, ST_RANGE, ST_EMPTY.
  - The bit-index rule: black = 2x, white = 2x+1. The renderer uses the same rule.
- Sub-module goboard_cmd_check (combinational):
  - Inputs: selected shadow row, op, x, y.
  - Outputs: status and the updated row.
  - Lets the legality rules be unit-tested separately.

Test Plan:
- Reset for 1 cycle, then release:
  - wEnable_o high for exactly 19 cycles with addr_o 0..18 and pieces_o = 0.
  - cmd_ready_o = 0 throughout, and no done_o.
  - cmd_ready_o rises on the cycle after addr_o = 18.
- Place black at (3,5):
  - Next cycle: wEnable_o = 1, addr_o = 5, pieces_o bit 6 = 1 and all other bits 0.
  - done_o = 1, status 00, black_cnt_o = 1.
- Then place white at (3,5):
  - done_o, status 01, no write, white_cnt_o = 0.
- Then place white at (4,5):
  - pieces_o has bits 6 and 9 set.
- Then remove (3,5):
  - pieces_o has only bit 9 set, black_cnt_o = 0.
- Then remove (3,5) again:
  - status 11, no write.
- Place at x = 19, y = 0:
  - status 10, no write.
- Place at x = 18, y = 18:
  - write to addr 18, pieces_o bit 36 set.
- With stones on rows 2 and 7, issue op 11:
  - 19 zero writes; done_o only on the addr 18 cycle; both counts 0 from the first clear cycle.
- Assert rst_i on the 2nd cycle of a CLEAR, and separately on a WRITE cycle:
  - the write sequence restarts at addr 0 and the counts read 0.
- Hold cmd_valid_i high with a stream of legal places:
  - commands are accepted every 2nd cycle, each with exactly one write and one done_o pulse.

Source files
------------

// File: rtl/goboard_pkg.sv
// Shared constants, op/status codes and the stone bit-index rule for the board pieces memory.
// A row holds 2 bits per column: bit 2x is a black stone at column x, bit 2x+1 is a white one.
package goboard_pkg;
   localparam int SIZE  = 19;
   localparam int AW    = 5;
   localparam int ROW_W = 2 * SIZE;
   localparam int CNT_W = 9;

   localparam logic [AW-1:0] SIZE_A   = AW'(SIZE);
   localparam logic [AW-1:0] LAST_ROW = AW'(SIZE - 1);

   typedef logic [ROW_W-1:0] row_t;

   typedef enum logic [1:0] {
      OP_PLACE_B = 2'b00,
      OP_PLACE_W = 2'b01,
      OP_REMOVE  = 2'b10,
      OP_CLEAR   = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_OK       = 2'b00,
      ST_OCCUPIED = 2'b01,
      ST_RANGE    = 2'b10,
      ST_EMPTY    = 2'b11
   } status_t;

   // Bit index of a stone in its row: 2x for black, 2x+1 for white. The renderer uses the same rule.
   function automatic logic [5:0] bit_idx(input logic [AW-1:0] x, input logic white);
      return {x, white};
   endfunction
endpackage

// File: rtl/goboard_if.sv
// Command handshake, completion status, memory write port and stone counts of the board writer.
// master = game logic side, slave = goboard_writer.
interface goboard_if;
   import goboard_pkg::*;

   logic               cmd_valid_i;
   logic               cmd_ready_o;
   logic [1:0]         cmd_op_i;
   logic [AW-1:0]      cmd_x_i;
   logic [AW-1:0]      cmd_y_i;
   logic               done_o;
   logic [1:0]         status_o;
   logic [AW-1:0]      addr_o;
   logic [ROW_W-1:0]   pieces_o;
   logic               wEnable_o;
   logic [CNT_W-1:0]   black_cnt_o;
   logic [CNT_W-1:0]   white_cnt_o;

   modport master (
      output cmd_valid_i, cmd_op_i, cmd_x_i, cmd_y_i,
      input  cmd_ready_o, done_o, status_o, addr_o, pieces_o, wEnable_o,
             black_cnt_o, white_cnt_o
   );

   modport slave (
      input  cmd_valid_i, cmd_op_i, cmd_x_i, cmd_y_i,
      output cmd_ready_o, done_o, status_o, addr_o, pieces_o, wEnable_o,
             black_cnt_o, white_cnt_o
   );
endinterface

// File: rtl/goboard_cmd_check.sv
// Combinational legality check of a place/remove against the selected shadow row; 0 cycles.
// Priority: out of range, then occupied (place), then empty (remove); new_row is only meaningful when ok.
module goboard_cmd_check
   import goboard_pkg::*;
(
   input  row_t          row,
   input  logic [1:0]    op,
   input  logic [AW-1:0] x,
   input  logic [AW-1:0] y,
   output logic [1:0]    status,
   output row_t          new_row,
   output logic [1:0]    point
);
   logic       in_range;
   logic [5:0] b_idx;

   assign in_range = (x < SIZE_A) && (y < SIZE_A);
   assign b_idx    = bit_idx(x, 1'b0);

   always_comb begin
      status  = ST_OK;
      new_row = row;
      point   = 2'b00;
      if (in_range) begin
         point = row[b_idx +: 2];
      end
      if (!in_range) begin
         status = ST_RANGE;
      end else if (op == OP_PLACE_B || op == OP_PLACE_W) begin
         if (point != 2'b00) begin
            status = ST_OCCUPIED;
         end else begin
            new_row[bit_idx(x, op[0])] = 1'b1;
         end
      end else if (op == OP_REMOVE) begin
         if (point == 2'b00) begin
            status = ST_EMPTY;
         end else begin
            new_row[b_idx +: 2] = 2'b00;
         end
      end
   end
endmodule

// File: rtl/goboard_writer.sv
// Board pieces writer: read-modify-write of a 19-row shadow, one memory row write 1 cycle after accept.
// cmd_ready_o only in IDLE: one command per 2 cycles, a clear occupies 20 cycles before the next accept.
module goboard_writer
   import goboard_pkg::*;
(
   input  logic      sys_clk_in,
   input  logic      rst_i,
   goboard_if.slave  bus
);
   localparam logic [1:0] S_CLEAR = 2'd0;
   localparam logic [1:0] S_IDLE  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   logic [1:0]    state;
   logic [AW-1:0] row_cnt;
   logic          quiet_clear;
   row_t          shadow [SIZE];
   row_t          sel_row;
   row_t          new_row;
   logic [1:0]    chk_status;
   logic [1:0]    point;
   logic          accept;

   assign bus.cmd_ready_o = (state == S_IDLE);
   assign accept          = bus.cmd_valid_i && bus.cmd_ready_o;
   assign sel_row         = (bus.cmd_y_i < SIZE_A) ? shadow[bus.cmd_y_i] : '0;

   goboard_cmd_check u_check (
      .row     (sel_row),
      .op      (bus.cmd_op_i),
      .x       (bus.cmd_x_i),
      .y       (bus.cmd_y_i),
      .status  (chk_status),
      .new_row (new_row),
      .point   (point)
   );

   always_ff @(posedge sys_clk_in) begin
      if (rst_i) begin
         for (int r = 0; r < SIZE; r++) begin
            shadow[r] <= '0;
         end
         bus.black_cnt_o <= '0;
         bus.white_cnt_o <= '0;
         bus.done_o      <= 1'b0;
         bus.status_o    <= 2'b00;
         bus.wEnable_o   <= 1'b0;
         bus.addr_o      <= '0;
         bus.pieces_o    <= '0;
         state           <= S_CLEAR;
         row_cnt         <= '0;
         quiet_clear     <= 1'b1;
      end else begin
         bus.done_o    <= 1'b0;
         bus.wEnable_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (bus.cmd_op_i == OP_CLEAR) begin
                     state           <= S_CLEAR;
                     row_cnt         <= '0;
                     quiet_clear     <= 1'b0;
                     bus.black_cnt_o <= '0;
                     bus.white_cnt_o <= '0;
                  end else if (chk_status != ST_OK) begin
                     bus.done_o   <= 1'b1;
                     bus.status_o <= chk_status;
                  end else begin
                     shadow[bus.cmd_y_i] <= new_row;
                     bus.wEnable_o       <= 1'b1;
                     bus.addr_o          <= bus.cmd_y_i;
                     bus.pieces_o        <= new_row;
                     bus.done_o          <= 1'b1;
                     bus.status_o        <= ST_OK;
                     state               <= S_WRITE;
                     // A remove decrements the colour actually found at the point
                     if (bus.cmd_op_i == OP_REMOVE) begin
                        if (point[0]) bus.black_cnt_o <= bus.black_cnt_o - 1'b1;
                        else          bus.white_cnt_o <= bus.white_cnt_o - 1'b1;
                     end else if (bus.cmd_op_i[0]) begin
                        bus.white_cnt_o <= bus.white_cnt_o + 1'b1;
                     end else begin
                        bus.black_cnt_o <= bus.black_cnt_o + 1'b1;
                     end
                  end
               end
            end
            S_WRITE: begin
               state <= S_IDLE;
            end
            S_CLEAR: begin
               // row_cnt == SIZE means the last row is on the port this cycle
               if (row_cnt == SIZE_A) begin
                  state <= S_IDLE;
               end else begin
                  shadow[row_cnt] <= '0;
                  bus.wEnable_o   <= 1'b1;
                  bus.addr_o      <= row_cnt;
                  bus.pieces_o    <= '0;
                  row_cnt         <= row_cnt + 1'b1;
                  if (row_cnt == LAST_ROW && !quiet_clear) begin
                     bus.done_o   <= 1'b1;
                     bus.status_o <= ST_OK;
                  end
               end
            end
            default: begin
               state   <= S_CLEAR;
               row_cnt <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_goboard_writer.sv
// Directed bench for goboard_writer: reset clear sweep, place/remove legality, clear, mid-op reset, streaming.
module tb_goboard_writer;
   import goboard_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   goboard_if bus ();

   goboard_writer dut (
      .sys_clk_in (clk),
      .rst_i      (rst),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [4:0] x, input logic [4:0] y, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !bus.cmd_ready_o; i++) tick();
      if (bus.cmd_ready_o) begin
         bus.cmd_op_i    = op;
         bus.cmd_x_i     = x;
         bus.cmd_y_i     = y;
         bus.cmd_valid_i = 1'b1;
         tick();
         bus.cmd_valid_i = 1'b0;
         ok = 1'b1;
      end
   endtask

   // Watches a clear sweep until cmd_ready_o rises (bounded) and reports what it saw.
   task automatic collect_clear(output int nwr, output int ndone, output bit seq_ok,
                                output bit done_ok, output bit cnt_ok, output bit rdy_ok);
      bit last18;
      nwr = 0; ndone = 0; seq_ok = 1'b1; done_ok = 1'b1; cnt_ok = 1'b1; rdy_ok = 1'b0; last18 = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (bus.cmd_ready_o) begin
            rdy_ok = last18 && (nwr == SIZE);
            break;
         end
         last18 = 1'b0;
         if (bus.wEnable_o) begin
            if (bus.addr_o !== 5'(nwr) || bus.pieces_o !== '0) seq_ok = 1'b0;
            last18 = (bus.addr_o == 5'd18);
            nwr++;
         end
         if (bus.done_o) begin
            ndone++;
            if (!(bus.wEnable_o && bus.addr_o == 5'd18)) done_ok = 1'b0;
         end
         if (bus.black_cnt_o !== 9'd0 || bus.white_cnt_o !== 9'd0) cnt_ok = 1'b0;
      end
   endtask

   task automatic test_reset;
      int nwr, nd; bit sq, dk, ck, rk;
      rst = 1'b1;
      tick();
      checks++; if (bus.wEnable_o !== 1'b0) begin failures++; $display("FAIL rst_wen act=%0h exp=0", bus.wEnable_o); end
      checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL rst_done act=%0h exp=0", bus.done_o); end
      checks++; if (bus.status_o !== 2'b00) begin failures++; $display("FAIL rst_status act=%0h exp=0", bus.status_o); end
      checks++; if (bus.addr_o !== 5'd0 || bus.pieces_o !== 38'h0) begin failures++; $display("FAIL rst_port act=%0h/%0h exp=0/0", bus.addr_o, bus.pieces_o); end
      checks++; if (bus.black_cnt_o !== 9'd0 || bus.white_cnt_o !== 9'd0) begin failures++; $display("FAIL rst_cnt act=%0d/%0d exp=0/0", bus.black_cnt_o, bus.white_cnt_o); end
      checks++; if (bus.cmd_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready act=%0h exp=0", bus.cmd_ready_o); end
      rst = 1'b0;
      collect_clear(nwr, nd, sq, dk, ck, rk);
      checks++; if (nwr != 19) begin failures++; $display("FAIL rst_clear_writes act=%0d exp=19", nwr); end
      checks++; if (!sq) begin failures++; $display("FAIL rst_clear_seq act=bad exp=addr0..18_zero"); end
      checks++; if (nd != 0) begin failures++; $display("FAIL rst_clear_done act=%0d exp=0", nd); end
      checks++; if (!rk) begin failures++; $display("FAIL rst_ready_rise act=not_after_addr18 exp=after_addr18"); end
   endtask

   task automatic test_place_remove;
      bit ok;
      issue(2'b00, 5'd3, 5'd5, ok);
      checks++; if (!ok) begin failures++; $display("FAIL pb_accept act=timeout exp=accepted"); end
      checks++; if (bus.wEnable_o !== 1'b1 || bus.addr_o !== 5'd5) begin failures++; $display("FAIL pb_write act=%0h/%0d exp=1/5", bus.wEnable_o, bus.addr_o); end
      checks++; if (bus.pieces_o !== 38'h40) begin failures++; $display("FAIL pb_pieces act=%0h exp=40", bus.pieces_o); end
      checks++; if (bus.done_o !== 1'b1 || bus.status_o !== 2'b00) begin failures++; $display("FAIL pb_done act=%0h/%0h exp=1/0", bus.done_o, bus.status_o); end
      checks++; if (bus.black_cnt_o !== 9'd1) begin failures++; $display("FAIL pb_cnt act=%0d exp=1", bus.black_cnt_o); end
      checks++; if (bus.cmd_ready_o !== 1'b0) begin failures++; $display("FAIL pb_ready_write act=%0h exp=0", bus.cmd_ready_o); end
      tick();
      checks++; if (bus.cmd_ready_o !== 1'b1 || bus.done_o !== 1'b0) begin failures++; $display("FAIL pb_ready_back act=%0h/%0h exp=1/0", bus.cmd_ready_o, bus.done_o); end

      issue(2'b01, 5'd3, 5'd5, ok);
      checks++; if (bus.done_o !== 1'b1 || bus.status_o !== 2'b01) begin failures++; $display("FAIL pw_occ act=%0h/%0h exp=1/1", bus.done_o, bus.status_o); end
      checks++; if (bus.wEnable_o !== 1'b0 || bus.white_cnt_o !== 9'd0) begin failures++; $display("FAIL pw_occ_nowrite act=%0h/%0d exp=0/0", bus.wEnable_o, bus.white_cnt_o); end

      issue(2'b01, 5'd4, 5'd5, ok);
      checks++; if (bus.wEnable_o !== 1'b1 || bus.pieces_o !== 38'h240) begin failures++; $display("FAIL pw_pieces act=%0h/%0h exp=1/240", bus.wEnable_o, bus.pieces_o); end
      checks++; if (bus.white_cnt_o !== 9'd1 || bus.black_cnt_o !== 9'd1) begin failures++; $display("FAIL pw_cnt act=%0d/%0d exp=1/1", bus.black_cnt_o, bus.white_cnt_o); end

      issue(2'b10, 5'd3, 5'd5, ok);
      checks++; if (bus.wEnable_o !== 1'b1 || bus.addr_o !== 5'd5 || bus.pieces_o !== 38'h200) begin failures++; $display("FAIL rm_pieces act=%0h/%0d/%0h exp=1/5/200", bus.wEnable_o, bus.addr_o, bus.pieces_o); end
      checks++; if (bus.black_cnt_o !== 9'd0 || bus.white_cnt_o !== 9'd1) begin failures++; $display("FAIL rm_cnt act=%0d/%0d exp=0/1", bus.black_cnt_o, bus.white_cnt_o); end

      issue(2'b10, 5'd3, 5'd5, ok);
      checks++; if (bus.done_o !== 1'b1 || bus.status_o !== 2'b11 || bus.wEnable_o !== 1'b0) begin failures++; $display("FAIL rm_empty act=%0h/%0h/%0h exp=1/3/0", bus.done_o, bus.status_o, bus.wEnable_o); end
   endtask

   task automatic test_bounds;
      bit ok;
      issue(2'b00, 5'd19, 5'd0, ok);
      checks++; if (bus.done_o !== 1'b1 || bus.status_o !== 2'b10 || bus.wEnable_o !== 1'b0) begin failures++; $display("FAIL range_x act=%0h/%0h/%0h exp=1/2/0", bus.done_o, bus.status_o, bus.wEnable_o); end
      issue(2'b10, 5'd0, 5'd25, ok);
      checks++; if (bus.status_o !== 2'b10 || bus.wEnable_o !== 1'b0) begin failures++; $display("FAIL range_y act=%0h/%0h exp=2/0", bus.status_o, bus.wEnable_o); end
      issue(2'b00, 5'd18, 5'd18, ok);
      checks++; if (bus.wEnable_o !== 1'b1 || bus.addr_o !== 5'd18 || bus.pieces_o !== 38'h10_0000_0000) begin failures++; $display("FAIL corner act=%0h/%0d/%0h exp=1/18/1000000000", bus.wEnable_o, bus.addr_o, bus.pieces_o); end
      checks++; if (bus.black_cnt_o !== 9'd1) begin failures++; $display("FAIL corner_cnt act=%0d exp=1", bus.black_cnt_o); end
   endtask

   task automatic test_clear;
      bit ok; int nwr, nd; bit sq, dk, ck, rk;
      issue(2'b00, 5'd1, 5'd2, ok);
      issue(2'b01, 5'd2, 5'd7, ok);
      checks++; if (bus.black_cnt_o !== 9'd2 || bus.white_cnt_o !== 9'd2) begin failures++; $display("FAIL pre_clear_cnt act=%0d/%0d exp=2/2", bus.black_cnt_o, bus.white_cnt_o); end
      issue(2'b11, 5'd0, 5'd0, ok);
      checks++; if (bus.black_cnt_o !== 9'd0 || bus.white_cnt_o !== 9'd0 || bus.done_o !== 1'b0) begin failures++; $display("FAIL clr_first act=%0d/%0d/%0h exp=0/0/0", bus.black_cnt_o, bus.white_cnt_o, bus.done_o); end
      collect_clear(nwr, nd, sq, dk, ck, rk);
      checks++; if (nwr != 19 || !sq) begin failures++; $display("FAIL clr_writes act=%0d/%0d exp=19/1", nwr, sq); end
      checks++; if (nd != 1 || !dk) begin failures++; $display("FAIL clr_done act=%0d/%0d exp=1/1", nd, dk); end
      checks++; if (!ck || !rk) begin failures++; $display("FAIL clr_cnt_ready act=%0d/%0d exp=1/1", ck, rk); end
      issue(2'b00, 5'd4, 5'd5, ok);
      checks++; if (bus.wEnable_o !== 1'b1 || bus.pieces_o !== 38'h100) begin failures++; $display("FAIL clr_shadow act=%0h/%0h exp=1/100", bus.wEnable_o, bus.pieces_o); end
   endtask

   task automatic test_reset_mid;
      bit ok; int nwr, nd; bit sq, dk, ck, rk;
      issue(2'b11, 5'd0, 5'd0, ok);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (bus.wEnable_o !== 1'b0 || bus.black_cnt_o !== 9'd0) begin failures++; $display("FAIL rmc_state act=%0h/%0d exp=0/0", bus.wEnable_o, bus.black_cnt_o); end
      collect_clear(nwr, nd, sq, dk, ck, rk);
      checks++; if (nwr != 19 || !sq || nd != 0 || !rk) begin failures++; $display("FAIL rmc_restart act=%0d/%0d/%0d/%0d exp=19/1/0/1", nwr, sq, nd, rk); end

      issue(2'b01, 5'd6, 5'd6, ok);
      checks++; if (bus.white_cnt_o !== 9'd1 || bus.wEnable_o !== 1'b1) begin failures++; $display("FAIL rmw_place act=%0d/%0h exp=1/1", bus.white_cnt_o, bus.wEnable_o); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (bus.white_cnt_o !== 9'd0 || bus.wEnable_o !== 1'b0) begin failures++; $display("FAIL rmw_state act=%0d/%0h exp=0/0", bus.white_cnt_o, bus.wEnable_o); end
      collect_clear(nwr, nd, sq, dk, ck, rk);
      checks++; if (nwr != 19 || !sq || !ck || !rk) begin failures++; $display("FAIL rmw_restart act=%0d/%0d/%0d/%0d exp=19/1/1/1", nwr, sq, ck, rk); end
   endtask

   task automatic test_back_to_back;
      int acc_n, last_acc, nwr, nd; bit gap_ok, acc; row_t last_p;
      acc_n = 0; last_acc = 0; nwr = 0; nd = 0; gap_ok = 1'b1; last_p = '0;
      for (int i = 0; i < 60 && !bus.cmd_ready_o; i++) tick();
      bus.cmd_op_i = 2'b00; bus.cmd_x_i = 5'd0; bus.cmd_y_i = 5'd10; bus.cmd_valid_i = 1'b1;
      for (int c = 0; c < 40; c++) begin
         acc = bus.cmd_ready_o && bus.cmd_valid_i;
         tick();
         if (bus.wEnable_o) begin nwr++; last_p = bus.pieces_o; end
         if (bus.done_o) nd++;
         if (acc) begin
            if (acc_n > 0 && (c - last_acc) != 2) gap_ok = 1'b0;
            last_acc = c;
            acc_n++;
            if (acc_n == 6) bus.cmd_valid_i = 1'b0;
            else begin bus.cmd_op_i = {1'b0, acc_n[0]}; bus.cmd_x_i = 5'(acc_n); end
         end
      end
      bus.cmd_valid_i = 1'b0;
      checks++; if (acc_n != 6 || !gap_ok) begin failures++; $display("FAIL b2b_accepts act=%0d/%0d exp=6/1", acc_n, gap_ok); end
      checks++; if (nwr != 6 || nd != 6) begin failures++; $display("FAIL b2b_writes act=%0d/%0d exp=6/6", nwr, nd); end
      checks++; if (last_p !== 38'h999) begin failures++; $display("FAIL b2b_row act=%0h exp=999", last_p); end
      checks++; if (bus.black_cnt_o !== 9'd3 || bus.white_cnt_o !== 9'd3) begin failures++; $display("FAIL b2b_cnt act=%0d/%0d exp=3/3", bus.black_cnt_o, bus.white_cnt_o); end
   endtask

   initial begin
      bus.cmd_valid_i = 1'b0;
      bus.cmd_op_i    = 2'b00;
      bus.cmd_x_i     = 5'd0;
      bus.cmd_y_i     = 5'd0;
      test_reset();
      test_place_remove();
      test_bounds();
      test_clear();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
